branch_redirect_ctrl: RTL and testbench

- Consumer side of the branch-decision path: takes the execute-stage resolution (taken flag, target, PC) and issues a registered PC-redirect request to fetch.
- Redirect uses a valid/ready handshake; the block drives pipeline flush while the redirect is pending and for a fixed number of cycles after it is accepted.
- Sits between EX (branch_decision plus ALU target adder) and the IF stage PC mux.

---
 rtl/branch_redirect_ctrl_pkg.sv | 29 ++
 rtl/branch_redirect_ctrl_bht_2bit.sv | 63 ++++++
 rtl/branch_redirect_ctrl.sv | 141 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
// Shared definitions for the branch redirect controller and its optional
// branch history table (enabled with the BRANCH_PREDICT_EN macro).
//   state_e    : controller state encoding (IDLE=0, PEND=1, FLUSH=2)
//   CNT_W      : width of the post-handshake flush counter (holds up to 15)
//   BHT_RESET  : reset value of every 2-bit predictor counter (weakly not-taken)
//   sat_update : 2-bit saturating counter step
// ---------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int         CNT_W     = 4;
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Count up on taken, down on not-taken, clamping at 3 and 0.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
// Branch history table of 2-bit saturating counters, indexed by
// pc[log2(ENTRIES)+1:2]. Only compiled with BRANCH_PREDICT_EN defined.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset (entries -> 2'b01)
//   lookup_pc     : fetch PC to predict
//   pred_taken    : combinational prediction (counter MSB) for lookup_pc
//   update_en     : apply an update on the next rising edge
//   update_pc     : PC of the resolved branch
//   update_taken  : resolved direction
// ---------------------------------------------------------------------------
`ifdef BRANCH_PREDICT_EN
module bht_2bit
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  input  logic            update_en,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]   lookup_idx;
  logic [IDX_W-1:0]   update_idx;
  logic [ENTRIES-1:0] taken_bits;

  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign update_idx = update_pc[IDX_W+1:2];

  // One register per entry so every counter can be reset asynchronously.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [1:0] ctr_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctr_reg <= BHT_RESET;
        end else if (update_en && (update_idx == IDX_W'(gi))) begin
          ctr_reg <= sat_update(ctr_reg, update_taken);
        end
      end

      assign taken_bits[gi] = ctr_reg[1];
    end
  endgenerate

  assign pred_taken = taken_bits[lookup_idx];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                            update_pc[XLEN-1:IDX_W+2], update_pc[1:0]};

endmodule
`endif

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
// Turns the EX-stage branch/jump resolution into a registered PC redirect
// request towards fetch (valid/ready), and holds the pipeline flush/stall
// while the redirect is pending plus FLUSH_CYCLES cycles after acceptance.
// Optional macro: BRANCH_PREDICT_EN adds a 2-bit BHT; redirects then only
// happen on mispredicts, and the fall-through target is i_ex_pc+4.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_ex_valid            : EX holds a valid instruction
//   i_ex_is_branch        : conditional branch
//   i_ex_is_jump          : JAL/JALR
//   i_branch_taken        : resolved branch condition
//   i_ex_pc, i_target     : EX PC and computed target
//   i_ex_pred_taken       : prediction carried with the instruction (macro only)
//   i_if_pc               : fetch PC for prediction lookup (macro only)
//   i_redirect_ready      : fetch accepts the redirect
//   o_redirect_valid/_pc  : redirect request and new PC (bits [1:0] are 0)
//   o_flush, o_ex_stall   : kill IF/ID, ID/EX; hold EX
//   o_pred_taken          : prediction for i_if_pc (0 without the macro)
// ---------------------------------------------------------------------------
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_ENTRIES  = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ex_valid,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_is_jump,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic            i_redirect_ready,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic            o_ex_stall,
  output logic            o_pred_taken
);

  state_e           state_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             redirect_valid_reg;
  logic             busy_reg;
  logic [XLEN-1:0]  redirect_pc_reg;

  logic             redirect_req;
  logic [XLEN-1:0]  redirect_target;

`ifdef BRANCH_PREDICT_EN
  logic ex_idle;
  assign ex_idle = (state_reg == IDLE);

  // Only a wrong prediction needs fetch to change course.
  assign redirect_req = i_ex_valid &
                        ((i_ex_is_branch & (i_branch_taken != i_ex_pred_taken)) |
                         (i_ex_is_jump & ~i_ex_pred_taken));
  // A mispredicted not-taken branch resumes at the fall-through PC (wraps mod 2^XLEN).
  assign redirect_target = (i_ex_is_jump | i_branch_taken) ? i_target
                                                           : i_ex_pc + XLEN'(4);

  // Resolutions arriving outside IDLE belong to flushed instructions and
  // must not train the table.
  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .XLEN    (XLEN)
  ) u_bht (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .lookup_pc    (i_if_pc),
    .pred_taken   (o_pred_taken),
    .update_en    (ex_idle & i_ex_valid & i_ex_is_branch),
    .update_pc    (i_ex_pc),
    .update_taken (i_branch_taken)
  );
`else
  assign redirect_req    = i_ex_valid & (i_ex_is_jump | (i_ex_is_branch & i_branch_taken));
  assign redirect_target = i_target;
  assign o_pred_taken    = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{i_ex_pred_taken, i_if_pc, i_ex_pc, 32'(BHT_ENTRIES)};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg          <= IDLE;
      flush_cnt_reg      <= '0;
      redirect_valid_reg <= 1'b0;
      busy_reg           <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (redirect_req) begin
            state_reg          <= PEND;
            redirect_pc_reg    <= {redirect_target[XLEN-1:2], 2'b00};
            redirect_valid_reg <= 1'b1;
            busy_reg           <= 1'b1;
          end
        end
        PEND: begin
          if (i_redirect_ready) begin
            state_reg          <= FLUSH;
            flush_cnt_reg      <= CNT_W'(FLUSH_CYCLES);
            redirect_valid_reg <= 1'b0;
          end
        end
        FLUSH: begin
          // Leaving on count 1 keeps flush high exactly FLUSH_CYCLES cycles
          // after the handshake cycle.
          if (flush_cnt_reg == CNT_W'(1)) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= '0;
            busy_reg      <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg          <= IDLE;
          flush_cnt_reg      <= '0;
          redirect_valid_reg <= 1'b0;
          busy_reg           <= 1'b0;
        end
      endcase
    end
  end

  assign o_redirect_valid = redirect_valid_reg;
  assign o_redirect_pc    = redirect_pc_reg;
  assign o_flush          = busy_reg;
  assign o_ex_stall       = busy_reg;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Table-driven vectors, hand-written multi-cycle sequences and a randomized
// run checked against a timestamp-based reference model.
// Optional macro: BRANCH_PREDICT_EN enables the predictor sequences/model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_redirect_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int BHT_ENTRIES  = 64;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_ex_valid = 1'b0;
  logic            i_ex_is_branch = 1'b0;
  logic            i_ex_is_jump = 1'b0;
  logic            i_branch_taken = 1'b0;
  logic [XLEN-1:0] i_ex_pc = '0;
  logic [XLEN-1:0] i_target = '0;
  logic            i_ex_pred_taken = 1'b0;
  logic [XLEN-1:0] i_if_pc = '0;
  logic            i_redirect_ready = 1'b0;
  logic            o_redirect_valid;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_flush;
  logic            o_ex_stall;
  logic            o_pred_taken;

  branch_redirect_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .BHT_ENTRIES  (BHT_ENTRIES)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_ex_valid       (i_ex_valid),
    .i_ex_is_branch   (i_ex_is_branch),
    .i_ex_is_jump     (i_ex_is_jump),
    .i_branch_taken   (i_branch_taken),
    .i_ex_pc          (i_ex_pc),
    .i_target         (i_target),
    .i_ex_pred_taken  (i_ex_pred_taken),
    .i_if_pc          (i_if_pc),
    .i_redirect_ready (i_redirect_ready),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_flush          (o_flush),
    .o_ex_stall       (o_ex_stall),
    .o_pred_taken     (o_pred_taken)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference-model predictor table (2-bit counters as plain integers).
  int bht_m [BHT_ENTRIES];

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic br, input logic jmp, input logic tk,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic pr);
    i_ex_valid      = v;
    i_ex_is_branch  = br;
    i_ex_is_jump    = jmp;
    i_branch_taken  = tk;
    i_ex_pc         = pc;
    i_target        = tgt;
    i_ex_pred_taken = pr;
  endtask

  task automatic clear_ex();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Accept any outstanding redirect and wait (bounded) for the block to go idle.
  task automatic drain(input string name);
    int k;
    k = 0;
    i_redirect_ready = 1'b1;
    while (o_ex_stall && k < 40) begin
      tick();
      k++;
    end
    check1(name, o_ex_stall, 1'b0);
    i_redirect_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check1({name, "_valid"}, o_redirect_valid, 1'b0);
    check1({name, "_flush"}, o_flush, 1'b0);
    check1({name, "_stall"}, o_ex_stall, 1'b0);
  endtask

`ifdef BRANCH_PREDICT_EN
  task automatic resolve_branch(input logic [XLEN-1:0] pc, input logic tk, input logic pr);
    drive_ex(1'b1, 1'b1, 1'b0, tk, pc, 32'h0000_0800, pr);
    tick();
    clear_ex();
    drain("train_drain");
  endtask
`endif

  function automatic logic model_pred(input logic [XLEN-1:0] pc);
`ifdef BRANCH_PREDICT_EN
    return bht_m[pc[7:2]] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  // Randomized run. The model keeps only two timestamps: the cycle a
  // redirect was issued and the cycle it was accepted; every output is
  // derived from those by the timing rules.
  task automatic random_run(input int cycles);
    longint c, t_issue, t_hs;
    logic [XLEN-1:0] m_pc;
    logic busy, e_valid, cond;
    logic [XLEN-1:0] tgt_e;
    logic [23:0] hi;
    logic [5:0]  ri;
    int kind, ix;
    c = 0;
    t_issue = -1;
    t_hs = -1;
    m_pc = '0;
    for (int n = 0; n < cycles; n++) begin
      busy    = (t_issue >= 0) && (c > t_issue) && ((t_hs < 0) || (c <= t_hs + FLUSH_CYCLES));
      e_valid = busy && (t_hs < 0);
      check1("rnd_valid", o_redirect_valid, e_valid);
      check1("rnd_flush", o_flush, busy);
      check1("rnd_stall", o_ex_stall, busy);
      if (e_valid) check32("rnd_pc", o_redirect_pc, m_pc);

      kind = $urandom_range(0, 3);
      hi = 24'($urandom);
      if ($urandom_range(0, 7) == 0) hi = 24'hFF_FFFF;
      ri = 6'($urandom_range(0, 3));
      if (ri == 6'd3) ri = 6'd63;
      i_ex_valid      = ($urandom_range(0, 3) != 0);
      i_ex_is_branch  = (kind == 1) || (kind == 3);
      i_ex_is_jump    = (kind == 2);
      i_branch_taken  = 1'($urandom_range(0, 1));
      i_ex_pred_taken = 1'($urandom_range(0, 1));
      i_ex_pc         = {hi, ri, 2'b00};
      i_target        = $urandom;
      ri = 6'($urandom_range(0, 3));
      if (ri == 6'd3) ri = 6'd63;
      i_if_pc          = {24'($urandom), ri, 2'b00};
      i_redirect_ready = ($urandom_range(0, 2) == 0);
      #1;
      check1("rnd_pred", o_pred_taken, model_pred(i_if_pc));

`ifdef BRANCH_PREDICT_EN
      cond  = i_ex_valid && ((i_ex_is_branch && (i_branch_taken != i_ex_pred_taken)) ||
                             (i_ex_is_jump && !i_ex_pred_taken));
      tgt_e = (i_ex_is_jump || i_branch_taken) ? i_target : i_ex_pc + 32'd4;
      if (!busy && i_ex_valid && i_ex_is_branch) begin
        ix = int'(i_ex_pc[7:2]);
        if (i_branch_taken) bht_m[ix] = (bht_m[ix] == 3) ? 3 : bht_m[ix] + 1;
        else                bht_m[ix] = (bht_m[ix] == 0) ? 0 : bht_m[ix] - 1;
      end
`else
      cond  = i_ex_valid && (i_ex_is_jump || (i_ex_is_branch && i_branch_taken));
      tgt_e = i_target;
      ix    = 0;
`endif
      if (busy && (t_hs < 0) && i_redirect_ready) begin
        t_hs = c;
      end else if (!busy && cond) begin
        t_issue = c;
        t_hs    = -1;
        m_pc    = tgt_e & ~32'd3;
      end
      tick();
      c++;
    end
    clear_ex();
    drain("rnd_drain");
  endtask

  typedef struct packed {
    logic            v;
    logic            br;
    logic            jmp;
    logic            tk;
    logic [XLEN-1:0] tgt;
    logic            exp_redir;
    logic [XLEN-1:0] exp_pc;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Rows: valid, branch, jump, taken, target, expect redirect, expected PC.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_1000};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1100, 1'b0, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1200, 1'b0, 32'h0000_0000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2002, 1'b1, 32'h0000_2000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1300, 1'b0, 32'h0000_0000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1400, 1'b0, 32'h0000_0000};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004};
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 1;

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    check32("reset_pc", o_redirect_pc, 32'h0);
    check1("reset_pred", o_pred_taken, 1'b0);
    i_rst_n = 1'b1;
    tick();

    // Table vectors: one resolution in IDLE, look one cycle later.
    for (int i = 0; i < 8; i++) begin
      drive_ex(tbl[i].v, tbl[i].br, tbl[i].jmp, tbl[i].tk, 32'h0000_0100, tbl[i].tgt, 1'b0);
      tick();
      clear_ex();
      check1($sformatf("tbl%0d_valid", i), o_redirect_valid, tbl[i].exp_redir);
      check1($sformatf("tbl%0d_flush", i), o_flush, tbl[i].exp_redir);
      check1($sformatf("tbl%0d_stall", i), o_ex_stall, tbl[i].exp_redir);
      if (tbl[i].exp_redir) check32($sformatf("tbl%0d_pc", i), o_redirect_pc, tbl[i].exp_pc);
      drain($sformatf("tbl%0d_drain", i));
    end

    // Taken BEQ with ready held high: exact flush window.
    i_redirect_ready = 1'b1;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0080, 1'b0);
    tick();
    clear_ex();
    check1("beq_n1_valid", o_redirect_valid, 1'b1);
    check32("beq_n1_pc", o_redirect_pc, 32'h0000_0080);
    check1("beq_n1_flush", o_flush, 1'b1);
    tick();
    check1("beq_n2_valid", o_redirect_valid, 1'b0);
    check1("beq_n2_flush", o_flush, 1'b1);
    tick();
    check1("beq_n3_flush", o_flush, 1'b1);
    check1("beq_n3_stall", o_ex_stall, 1'b1);
    tick();
    check_idle_outputs("beq_n4");
    i_redirect_ready = 1'b0;

    // Ready without a request has no effect.
    i_redirect_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle_outputs("ready_only");
    end
    i_redirect_ready = 1'b0;

    // Backpressure: held PC, second resolution during PEND dropped.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_01F0, 32'h0000_0200, 1'b0);
    tick();
    clear_ex();
    for (int k = 0; k < 5; k++) begin
      check1("bp_valid", o_redirect_valid, 1'b1);
      check32("bp_pc", o_redirect_pc, 32'h0000_0200);
      check1("bp_flush", o_flush, 1'b1);
      if (k == 2) drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_02F0, 32'h0000_0300, 1'b0);
      tick();
      clear_ex();
    end
    check1("bp_hold_valid", o_redirect_valid, 1'b1);
    check32("bp_hold_pc", o_redirect_pc, 32'h0000_0200);
    i_redirect_ready = 1'b1;
    tick();
    i_redirect_ready = 1'b0;
    check1("bp_hs_valid", o_redirect_valid, 1'b0);
    check1("bp_hs_flush", o_flush, 1'b1);
    tick();
    check1("bp_f2_flush", o_flush, 1'b1);
    tick();
    check_idle_outputs("bp_done");
    tick();
    tick();
    check_idle_outputs("bp_dropped");

    // Reset asserted during PEND clears outputs without a clock edge.
    drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0600, 1'b0);
    tick();
    clear_ex();
    check1("rst_pend_valid", o_redirect_valid, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    check32("rst_async_pc", o_redirect_pc, 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check_idle_outputs("rst_release");
    drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0400, 1'b0);
    tick();
    clear_ex();
    check1("rst_after_valid", o_redirect_valid, 1'b1);
    check32("rst_after_pc", o_redirect_pc, 32'h0000_0400);
    drain("rst_after_drain");

`ifdef BRANCH_PREDICT_EN
    // Predicted taken, actually not taken at the top of the address space.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0050, 1'b1);
    tick();
    clear_ex();
    check1("wrap_valid", o_redirect_valid, 1'b1);
    check32("wrap_pc", o_redirect_pc, 32'h0000_0000);
    drain("wrap_drain");

    // Train one entry: 01 -> 10 -> 11 -> 11 (sat) -> 10 -> 01.
    i_if_pc = 32'h0000_0340;
    #1;
    check1("train_init", o_pred_taken, 1'b0);
    resolve_branch(32'h0000_0340, 1'b1, 1'b0);
    check1("train_t1", o_pred_taken, 1'b1);
    resolve_branch(32'h0000_0340, 1'b1, 1'b1);
    check1("train_t2", o_pred_taken, 1'b1);
    resolve_branch(32'h0000_0340, 1'b1, 1'b1);
    check1("train_t3", o_pred_taken, 1'b1);
    resolve_branch(32'h0000_0340, 1'b0, 1'b1);
    check1("train_nt1", o_pred_taken, 1'b1);
    resolve_branch(32'h0000_0340, 1'b0, 1'b1);
    check1("train_nt2", o_pred_taken, 1'b0);

    // A correctly predicted taken branch causes no redirect.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0900, 1'b1);
    tick();
    clear_ex();
    check_idle_outputs("pred_ok");
`endif

    // Fresh reset so the reference model's table matches the DUT.
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 1;
    random_run(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
